// File: rtl/memory_stage.sv
// Memory stage of the five-stage MIPS pipeline: waits for data-memory responses,
// aligns/extends load data, feeds bypass and writeback, and drops responses orphaned by flushes.

package memory_stage_pkg;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [3:0]  rf_we;
        logic [31:0] result;
        logic        mem_load;
        logic        mem_req;
        logic [2:0]  load_type;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        logic [2:0]  tlb_op;
        logic [4:0]  cache_op;
        logic [31:0] phy_addr;
        exception_t  exception;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [3:0]  rf_we;
        logic [31:0] result;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        logic [2:0]  tlb_op;
        logic [4:0]  cache_op;
        logic [31:0] phy_addr;
        exception_t  exception;
    } ms_to_ws_bus_t;

endpackage

module memory_stage_chk (
    input logic       clk,
    input logic       reset,
    input logic [1:0] discard_cnt
);
    // the discard counter must never reach its saturation value
    assert property (@(posedge clk) disable iff (reset) discard_cnt != 2'd3)
        else $error("discard counter saturated");
endmodule

module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          es_to_valid,
    output logic          ms_allowin,
    input  es_to_ms_bus_t es_to_ms_bus,
    output logic          ms_to_ws_valid,
    input  logic          ws_allowin,
    output ms_to_ws_bus_t ms_to_ws_bus,
    input  logic          data_ok,
    input  logic [31:0]   rdata,
    input  logic          pipeline_flush,
    output logic [4:0]    ms_dest,
    output logic [31:0]   ms_result,
    output logic          ms_load_pending,
    output logic          ms_ex_eret
);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LWL = 3'd5;
    localparam logic [2:0] LT_LWR = 3'd6;

    logic          ms_valid_q, ms_valid_d;
    es_to_ms_bus_t bus_q, bus_d;
    logic          resp_got_q, resp_got_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic [1:0]    discard_cnt_q, discard_cnt_d;

    logic          need_resp_s, resp_avail_s, ms_ready_go_s, capture_s;
    logic [1:0]    flush_inc_s;
    logic [2:0]    cnt_sum_s;
    logic [31:0]   load_data_s, final_result_s;
    logic [3:0]    final_we_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;

    // handshake with execute and writeback
    always_comb begin
        need_resp_s    = bus_q.mem_req & ~bus_q.exception.ex;
        resp_avail_s   = resp_got_q | (data_ok & (discard_cnt_q == 2'd0));
        ms_ready_go_s  = ~need_resp_s | resp_avail_s;
        ms_allowin     = ~ms_valid_q | (ms_ready_go_s & ws_allowin);
        ms_to_ws_valid = ms_valid_q & ms_ready_go_s;
    end

    // next-state for valid, bus, response buffer and discard counter
    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        resp_got_d  = resp_got_q;
        resp_data_d = resp_data_q;
        capture_s   = data_ok & (discard_cnt_q == 2'd0) & ms_valid_q & need_resp_s
                    & ~resp_got_q & ~ws_allowin;

        if (pipeline_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end

        if (es_to_valid & ms_allowin) begin
            bus_d = es_to_ms_bus;
        end else begin
            bus_d = bus_q;
        end

        if (pipeline_flush | (ms_to_ws_valid & ws_allowin)) begin
            resp_got_d = 1'b0;
        end else if (capture_s) begin
            resp_got_d  = 1'b1;
            resp_data_d = rdata;
        end else begin
            resp_got_d = resp_got_q;
        end

        // requests that will never be consumed once the flush lands
        if (pipeline_flush) begin
            flush_inc_s = {1'b0, ms_valid_q & need_resp_s & ~resp_avail_s}
                        + {1'b0, es_to_valid & ms_allowin & es_to_ms_bus.mem_req};
        end else begin
            flush_inc_s = 2'd0;
        end
        cnt_sum_s = {1'b0, discard_cnt_q} + {1'b0, flush_inc_s}
                  - {2'd0, data_ok & (discard_cnt_q != 2'd0)};
        if (cnt_sum_s > 3'd3) begin
            discard_cnt_d = 2'd3;
        end else begin
            discard_cnt_d = cnt_sum_s[1:0];
        end
    end

    // load data selection, alignment and extension
    always_comb begin
        load_data_s    = resp_got_q ? resp_data_q : rdata;
        half_s         = bus_q.result[1] ? load_data_s[31:16] : load_data_s[15:0];
        final_result_s = bus_q.result;
        final_we_s     = bus_q.rf_we;
        case (bus_q.result[1:0])
            2'd0:    byte_s = load_data_s[7:0];
            2'd1:    byte_s = load_data_s[15:8];
            2'd2:    byte_s = load_data_s[23:16];
            2'd3:    byte_s = load_data_s[31:24];
            default: byte_s = 8'd0;
        endcase
        if (bus_q.mem_load & ~bus_q.exception.ex) begin
            case (bus_q.load_type)
                LT_LW:   final_result_s = load_data_s;
                LT_LB:   final_result_s = {{24{byte_s[7]}}, byte_s};
                LT_LBU:  final_result_s = {24'd0, byte_s};
                LT_LH:   final_result_s = {{16{half_s[15]}}, half_s};
                LT_LHU:  final_result_s = {16'd0, half_s};
                LT_LWL: begin
                    case (bus_q.result[1:0])
                        2'd0:    begin final_result_s = {load_data_s[7:0], 24'd0};  final_we_s = 4'b1000; end
                        2'd1:    begin final_result_s = {load_data_s[15:0], 16'd0}; final_we_s = 4'b1100; end
                        2'd2:    begin final_result_s = {load_data_s[23:0], 8'd0};  final_we_s = 4'b1110; end
                        default: begin final_result_s = load_data_s;                final_we_s = 4'b1111; end
                    endcase
                end
                LT_LWR: begin
                    case (bus_q.result[1:0])
                        2'd0:    begin final_result_s = load_data_s;                 final_we_s = 4'b1111; end
                        2'd1:    begin final_result_s = {8'd0, load_data_s[31:8]};   final_we_s = 4'b0111; end
                        2'd2:    begin final_result_s = {16'd0, load_data_s[31:16]}; final_we_s = 4'b0011; end
                        default: begin final_result_s = {24'd0, load_data_s[31:24]}; final_we_s = 4'b0001; end
                    endcase
                end
                default: final_result_s = bus_q.result;
            endcase
        end else begin
            final_result_s = bus_q.result;
        end
    end

    // outputs to writeback and the bypass network
    always_comb begin
        ms_to_ws_bus.pc        = bus_q.pc;
        ms_to_ws_bus.dest      = bus_q.dest;
        ms_to_ws_bus.rf_we     = final_we_s;
        ms_to_ws_bus.result    = final_result_s;
        ms_to_ws_bus.c0_op     = bus_q.c0_op;
        ms_to_ws_bus.c0_addr   = bus_q.c0_addr;
        ms_to_ws_bus.tlb_op    = bus_q.tlb_op;
        ms_to_ws_bus.cache_op  = bus_q.cache_op;
        ms_to_ws_bus.phy_addr  = bus_q.phy_addr;
        ms_to_ws_bus.exception = bus_q.exception;
        ms_dest         = ms_valid_q ? bus_q.dest : 5'd0;
        ms_result       = final_result_s;
        ms_load_pending = ms_valid_q & bus_q.mem_load & ~resp_avail_s;
        ms_ex_eret      = ms_valid_q & (bus_q.exception.ex | bus_q.c0_op[0]);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            resp_got_q    <= 1'b0;
            resp_data_q   <= 32'd0;
            discard_cnt_q <= 2'd0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            bus_q         <= bus_d;
            resp_got_q    <= resp_got_d;
            resp_data_q   <= resp_data_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    memory_stage_chk u_chk (
        .clk         (clk),
        .reset       (reset),
        .discard_cnt (discard_cnt_q)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk;
    logic          reset;
    logic          es_to_valid;
    logic          ms_allowin;
    es_to_ms_bus_t es_to_ms_bus;
    logic          ms_to_ws_valid;
    logic          ws_allowin;
    ms_to_ws_bus_t ms_to_ws_bus;
    logic          data_ok;
    logic [31:0]   rdata;
    logic          pipeline_flush;
    logic [4:0]    ms_dest;
    logic [31:0]   ms_result;
    logic          ms_load_pending;
    logic          ms_ex_eret;

    int passed = 0;
    int total  = 0;

    logic [31:0] sw_exp [8];
    logic [3:0]  sw_we  [8];

    memory_stage dut (
        .clk             (clk),
        .reset           (reset),
        .es_to_valid     (es_to_valid),
        .ms_allowin      (ms_allowin),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_ok         (data_ok),
        .rdata           (rdata),
        .pipeline_flush  (pipeline_flush),
        .ms_dest         (ms_dest),
        .ms_result       (ms_result),
        .ms_load_pending (ms_load_pending),
        .ms_ex_eret      (ms_ex_eret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic es_to_ms_bus_t mk(input logic [2:0] lt, input logic is_mem,
                                         input logic [31:0] res, input logic [4:0] dest);
        es_to_ms_bus_t b;
        b           = '0;
        b.pc        = 32'hBFC0_0000 | {25'd0, dest, 2'b00};
        b.dest      = dest;
        b.rf_we     = 4'hF;
        b.result    = res;
        b.mem_load  = is_mem;
        b.mem_req   = is_mem;
        b.load_type = lt;
        return b;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] we);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = we[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        return r;
    endfunction

    initial begin
        sw_exp = '{32'hDD22_3344, 32'hCCDD_3344, 32'hBBCC_DD44, 32'hAABB_CCDD,
                   32'hAABB_CCDD, 32'h11AA_BBCC, 32'h1122_AABB, 32'h1122_33AA};
        sw_we  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

        reset = 1'b1; es_to_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_ok = 1'b0; rdata = 32'd0; pipeline_flush = 1'b0;
        cyc(); cyc();
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_dest", 32'(ms_dest), 32'd0);
        chk("rst_pending", 32'(ms_load_pending), 32'd0);
        chk("rst_eret", 32'(ms_ex_eret), 32'd0);
        reset = 1'b0;

        // non-memory op passes through in one cycle
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b0, 32'hDEAD_BEEF, 5'd5);
        cyc(); es_to_valid = 1'b0; #1;
        chk("alu_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("alu_dest", 32'(ms_dest), 32'd5);
        chk("alu_result", ms_to_ws_bus.result, 32'hDEAD_BEEF);
        chk("alu_we", 32'(ms_to_ws_bus.rf_we), 32'hF);
        cyc();
        chk("alu_gone", 32'(ms_to_ws_valid), 32'd0);

        // LW back-to-back
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0100, 5'd1);
        cyc();
        es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0104, 5'd2); #1;
        chk("lw1_wait_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("lw1_wait_pending", 32'(ms_load_pending), 32'd1);
        chk("lw1_wait_allowin", 32'(ms_allowin), 32'd0);
        data_ok = 1'b1; rdata = 32'h1234_5678; #1;
        chk("lw1_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lw1_allowin", 32'(ms_allowin), 32'd1);
        chk("lw1_result", ms_result, 32'h1234_5678);
        chk("lw1_pending", 32'(ms_load_pending), 32'd0);
        cyc();
        es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0108, 5'd3); #1;
        chk("lw2_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lw2_dest", 32'(ms_dest), 32'd2);
        chk("lw2_result", ms_to_ws_bus.result, 32'h1234_5678);
        cyc();
        es_to_valid = 1'b0; #1;
        chk("lw3_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lw3_dest", 32'(ms_to_ws_bus.dest), 32'd3);
        cyc();
        data_ok = 1'b0; #1;
        chk("lw_idle", 32'(ms_to_ws_valid), 32'd0);

        // LB / LBU / LH
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd1, 1'b1, 32'h0000_0103, 5'd4);
        cyc();
        es_to_ms_bus = mk(3'd2, 1'b1, 32'h0000_0103, 5'd4);
        data_ok = 1'b1; rdata = 32'h80FF_FF7F; #1;
        chk("lb_a3", ms_to_ws_bus.result, 32'hFFFF_FF80);
        cyc();
        es_to_ms_bus = mk(3'd3, 1'b1, 32'h0000_0102, 5'd4); #1;
        chk("lbu_a3", ms_to_ws_bus.result, 32'h0000_0080);
        cyc();
        es_to_valid = 1'b0; #1;
        chk("lh_a2", ms_to_ws_bus.result, 32'hFFFF_80FF);
        cyc();
        data_ok = 1'b0;

        // LWL / LWR sweep over all offsets
        es_to_valid = 1'b1;
        es_to_ms_bus = mk(3'd5, 1'b1, 32'h0000_0400, 5'd6);
        rdata = 32'hAABB_CCDD;
        for (int i = 0; i < 8; i++) begin
            cyc();
            data_ok = 1'b1;
            if (i < 7) es_to_ms_bus = mk((i + 1 < 4) ? 3'd5 : 3'd6, 1'b1, 32'h400 + 32'((i + 1) % 4), 5'd6);
            else es_to_valid = 1'b0;
            #1;
            chk($sformatf("lwlr%0d_we", i), 32'(ms_to_ws_bus.rf_we), 32'(sw_we[i]));
            chk($sformatf("lwlr%0d_data", i),
                merge(32'h1122_3344, ms_to_ws_bus.result, ms_to_ws_bus.rf_we), sw_exp[i]);
        end
        cyc();
        data_ok = 1'b0;

        // backpressure: response arrives while writeback stalls for 3 cycles
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0200, 5'd7);
        cyc();
        es_to_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D; #1;
        chk("bp_c1_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("bp_c1_allowin", 32'(ms_allowin), 32'd0);
        chk("bp_c1_pending", 32'(ms_load_pending), 32'd0);
        cyc();
        data_ok = 1'b0; rdata = 32'h0000_0000; #1;
        chk("bp_c2_result", ms_result, 32'hCAFE_F00D);
        chk("bp_c2_pending", 32'(ms_load_pending), 32'd0);
        cyc();
        chk("bp_c3_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("bp_c3_result", ms_to_ws_bus.result, 32'hCAFE_F00D);
        ws_allowin = 1'b1; #1;
        chk("bp_release_allowin", 32'(ms_allowin), 32'd1);
        chk("bp_release_result", ms_to_ws_bus.result, 32'hCAFE_F00D);
        cyc();
        chk("bp_single_handoff", 32'(ms_to_ws_valid), 32'd0);

        // flush with an outstanding load, then a flush admitting a new load
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0300, 5'd8);
        cyc();
        es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0304, 5'd9); pipeline_flush = 1'b1; #1;
        chk("fl1_allowin", 32'(ms_allowin), 32'd0);
        cyc();
        es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0308, 5'd10); #1;
        chk("fl1_cnt", 32'(dut.discard_cnt_q), 32'd1);
        chk("fl2_allowin", 32'(ms_allowin), 32'd1);
        cyc();
        pipeline_flush = 1'b0; es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_030C, 5'd11); #1;
        chk("fl2_cnt", 32'(dut.discard_cnt_q), 32'd2);
        chk("fl2_valid", 32'(ms_to_ws_valid), 32'd0);
        cyc();
        es_to_valid = 1'b0; data_ok = 1'b1; rdata = 32'hBAD0_0001; #1;
        chk("disc1_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("disc1_pending", 32'(ms_load_pending), 32'd1);
        cyc();
        rdata = 32'hBAD0_0002; #1;
        chk("disc2_cnt", 32'(dut.discard_cnt_q), 32'd1);
        chk("disc2_valid", 32'(ms_to_ws_valid), 32'd0);
        cyc();
        rdata = 32'h600D_600D; #1;
        chk("deliver_cnt", 32'(dut.discard_cnt_q), 32'd0);
        chk("deliver_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("deliver_result", ms_to_ws_bus.result, 32'h600D_600D);
        chk("deliver_dest", 32'(ms_dest), 32'd11);
        cyc();
        data_ok = 1'b0; #1;
        chk("deliver_done", 32'(ms_to_ws_valid), 32'd0);

        // eret and an excepting load (no response expected)
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b0, 32'd0, 5'd0);
        es_to_ms_bus.c0_op = 3'b001;
        cyc();
        es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0505, 5'd12);
        es_to_ms_bus.exception.ex = 1'b1; es_to_ms_bus.exception.excode = 5'd4; #1;
        chk("eret_flag", 32'(ms_ex_eret), 32'd1);
        cyc();
        es_to_valid = 1'b0; #1;
        chk("exc_eret", 32'(ms_ex_eret), 32'd1);
        chk("exc_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("exc_code", 32'(ms_to_ws_bus.exception.excode), 32'd4);
        chk("exc_result", ms_to_ws_bus.result, 32'h0000_0505);
        cyc();

        // reset while a load waits for data
        es_to_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 32'h0000_0600, 5'd13);
        cyc();
        es_to_valid = 1'b0; #1;
        chk("rmw_pending", 32'(ms_load_pending), 32'd1);
        reset = 1'b1;
        cyc();
        chk("rmw_allowin", 32'(ms_allowin), 32'd1);
        chk("rmw_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rmw_dest", 32'(ms_dest), 32'd0);
        chk("rmw_pending0", 32'(ms_load_pending), 32'd0);
        chk("rmw_eret", 32'(ms_ex_eret), 32'd0);
        chk("rmw_cnt", 32'(dut.discard_cnt_q), 32'd0);
        reset = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage MIPS pipeline, between execute and writeback. Accepts the execute bus, waits for the data-memory response of any request issued in execute, and aligns and extends load data. It forwards the result to the register bypass network and hands `ms_to_ws_bus_t` to writeback. It also tracks requests that were cancelled by a pipeline flush, so that their late responses are discarded.

## Interface
- No parameters.
- `clk  in  1`  pipeline clock
- `reset  in  1`  synchronous, active-high
- `es_to_valid  in  1`  execute has a valid instruction
- `ms_allowin  out  1`  stage can accept this cycle
- `es_to_ms_bus  in  es_to_ms_bus_t`  fields:
  - `pc`, `dest`, `rf_we[3:0]`
  - `result`: ALU result, or vaddr for memory ops
  - `mem_load`, `mem_req` (request accepted in EX), `load_type[2:0]`
  - `c0_op`, `c0_addr`, `tlb_op`, `cache_op`, `phy_addr`, `exception`
- `ms_to_ws_valid  out  1`  valid toward writeback
- `ws_allowin  in  1`  writeback can accept
- `ms_to_ws_bus  out  ms_to_ws_bus_t`  registered fields plus the final `result` and final `rf_we`
- `data_ok  in  1`  data-memory response strobe, one per request, in order
- `rdata  in  32`  response data
- `pipeline_flush  in  1`  from writeback
- `ms_dest  out  5`  bypass destination, 0 when not valid
- `ms_result  out  32`  bypass value
- `ms_load_pending  out  1`  `ms_valid & mem_load & !resp_avail`; decode must stall on a match
- `ms_ex_eret  out  1`  `ms_valid & (exception.ex | c0_op[0])`; execute must suppress new stores

## Operation
- **`ms_valid` update:**
  - Cleared on `reset` or `pipeline_flush`.
  - Otherwise, when `ms_allowin`, loads `es_to_valid`.
  - The bus register loads when `es_to_valid & ms_allowin`.
- **Handshake:**
  - `need_resp = mem_req & !exception.ex`.
  - `resp_avail = resp_got | (data_ok & discard_cnt==0)`.
  - `ms_ready_go = !need_resp | resp_avail`.
  - `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
  - `ms_to_ws_valid = ms_valid & ms_ready_go`.
- **Response buffer:**
  - Condition: `data_ok` arrives with `discard_cnt==0`, `ms_valid & need_resp & !resp_got`, and `ws_allowin` is low.
  - Action: latch `rdata` into `resp_data` and set `resp_got`.
  - `resp_got` clears when the instruction moves to WB, or on flush or reset.
  - Effective load data is `resp_got ? resp_data : rdata`.
- **Discard counter:** `discard_cnt`, 2 bits.
  - On `pipeline_flush`, add the number of requests that will never be consumed:
    - `(ms_valid & need_resp & !resp_avail)`
    - plus `(es_to_valid & ms_allowin & es_to_ms_bus.mem_req)`.
  - Any `data_ok` while `discard_cnt != 0` decrements it and is ignored.
  - Increment and decrement in the same cycle net out.
  - Saturates at 3; reaching 3 is an assertion failure.
- **Load alignment:** `a = result[1:0]`. Load codes: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR.
  - LB/LBU: byte `a`, sign- or zero-extended to 32 bits.
  - LH/LHU: half at `a[1]`, sign- or zero-extended.
  - LW: full word.
  - LWL, `rf_we` by offset 0/1/2/3: 1000 / 1100 / 1110 / 1111. The low `a+1` bytes of the word go to the top of the register.
  - LWR, `rf_we` by offset 0/1/2/3: 1111 / 0111 / 0011 / 0001. The top `4-a` bytes of the word go to the bottom of the register.
  - Non-load results pass `result` through unchanged, with the bus `rf_we`.
- **Exceptions:** carried unchanged. No response is expected when `exception.ex` is set.

## Timing
- **Reset values:**
  - `ms_valid` 0, `resp_got` 0, `discard_cnt` 0.
  - `ms_to_ws_valid` 0, `ms_allowin` 1.
  - `ms_dest` 0, `ms_load_pending` 0, `ms_ex_eret` 0.
- **Latency:**
  - Non-memory ops: 1 cycle through the stage.
  - Loads: at least 1 cycle. The earliest `data_ok` is the cycle after entry, and the instruction leaves in that same cycle if `ws_allowin`.
- **Combinational paths:**
  - `ms_allowin` is combinational on `data_ok` and `ws_allowin`.
  - Bypass outputs are combinational on `data_ok`/`rdata`.
- **Flush:** takes effect at the next edge. A `data_ok` in the flush cycle for the flushed instruction is counted as consumed, not discarded.

## Test plan
- **LW back-to-back:** `data_ok` the cycle after each entry, `ws_allowin`=1 → one instruction per cycle to WB, `rdata` 0x12345678 forwarded unchanged.
- **LB / LBU:** at `a`=3, `rdata` 0x80FF_FF7F → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at `a`=2 → 0xFFFF80FF.
- **LWL/LWR sweep:** `rdata` 0xAABBCCDD, register old value 0x11223344, all four offsets → byte enables and data as listed in Operation (e.g. LWL `a`=1: `rf_we` 1100, upper half 0xCCDD).
- **Backpressure:** `data_ok` arrives while `ws_allowin`=0 for 3 cycles → data is held, `ms_load_pending`=0, exactly one WB handoff with the correct data.
- **Flush with outstanding load:** load waiting in MS plus a new load entering in the flush cycle → `discard_cnt`=2, the next two `data_ok` are ignored, the third is delivered to a subsequent load.
- **Reset mid-wait:** load waiting for data, `reset` asserted → all outputs return to reset values on the next edge.
